// File: rtl/sbox_pkg.sv
// Shared types and constants for the masked S-box sequencer and its guard LFSR.
package sbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sbox_seq_state_t;

    // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] SBOX_LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] SBOX_DEFAULT_SEED = 32'hACE1_2468;

    function automatic int sbox_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sbox_seq_ctrl_if.sv
// Round-controller / regfile / S-box handshake bundle of the sequencer.
// With SBOX_SEQ_STALL_EN defined, the bundle carries the rnd_ok stall input.
interface sbox_seq_ctrl_if #(
    parameter int NBYTES  = 16,
    parameter int GUARD_W = 32
);
    import sbox_pkg::*;

    localparam int AW = sbox_addr_w(NBYTES);

    logic               start;
    logic               seed_ld;
    logic [31:0]        seed_i;
`ifdef SBOX_SEQ_STALL_EN
    logic               rnd_ok;
`endif
    logic               busy;
    logic               done;
    logic [AW-1:0]      rd_addr;
    logic               sbox_vld;
    logic [GUARD_W-1:0] guards;
    logic [AW-1:0]      wr_addr;
    logic               wr_en;

    modport master (
`ifdef SBOX_SEQ_STALL_EN
        output rnd_ok,
`endif
        output start, seed_ld, seed_i,
        input  busy, done, rd_addr, sbox_vld, guards, wr_addr, wr_en
    );

    modport slave (
`ifdef SBOX_SEQ_STALL_EN
        input  rnd_ok,
`endif
        input  start, seed_ld, seed_i,
        output busy, done, rd_addr, sbox_vld, guards, wr_addr, wr_en
    );

endinterface

// File: rtl/sbox_seq_ctrl_guard_lfsr.sv
// guard_lfsr: seeded right-shifting Galois LFSR; a zero load value is replaced
// by SEED so the register can never lock up at all-zeros.
module guard_lfsr
    import sbox_pkg::*;
#(
    parameter int              WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(SBOX_LFSR_POLY),
    parameter logic [WIDTH-1:0] SEED = WIDTH'(SBOX_DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] state_next;

    always_comb begin
        state_next = state_reg;
        if (load) begin
            state_next = (load_val == '0) ? SEED : load_val;
        end else if (step) begin
            state_next = {1'b0, state_reg[WIDTH-1:1]} ^ (state_reg[0] ? POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SEED;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/sbox_seq_ctrl.sv
// Sequencer walking NBYTES masked bytes through a LAT-deep S-box pipeline and
// writing results back in order. Optional rnd_ok stalling via SBOX_SEQ_STALL_EN.
module sbox_seq_ctrl
    import sbox_pkg::*;
#(
    parameter int          NBYTES  = 16,
    parameter int          LAT     = 4,
    parameter int          GUARD_W = 32,
    parameter logic [31:0] SEED    = SBOX_DEFAULT_SEED
) (
    input  logic          clk,
    input  logic          rst,
    sbox_seq_ctrl_if.slave bus
);

    localparam int            AW        = sbox_addr_w(NBYTES);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NBYTES - 1);

    sbox_seq_state_t state_reg;
    logic [AW-1:0]   rd_addr_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            rnd_ok_int;
    logic            issue_en;
    logic            seed_load;
    logic            wb_vld;
    logic [AW-1:0]   wb_addr;
    logic            last_wr;
    logic [31:0]     lfsr_state;

`ifdef SBOX_SEQ_STALL_EN
    assign rnd_ok_int = bus.rnd_ok;
`else
    assign rnd_ok_int = 1'b1;
`endif

    assign issue_en  = (state_reg == ST_ISSUE) && rnd_ok_int;
    assign seed_load = (state_reg == ST_IDLE) && bus.seed_ld;
    assign last_wr   = wb_vld && (wb_addr == LAST_ADDR);

    // The LFSR only advances on real issues, so stalled cycles burn no randomness.
    guard_lfsr #(
        .WIDTH (32),
        .POLY  (SBOX_LFSR_POLY),
        .SEED  (SEED)
    ) u_guard_lfsr (
        .clk      (clk),
        .rst      (rst),
        .step     (issue_en),
        .load     (seed_load),
        .load_val (bus.seed_i),
        .state    (lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            rd_addr_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start && !bus.seed_ld) begin
                        state_reg   <= ST_ISSUE;
                        rd_addr_reg <= '0;
                        busy_reg    <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (issue_en) begin
                        if (rd_addr_reg == LAST_ADDR) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            rd_addr_reg <= rd_addr_reg + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_wr) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // In-flight tracker: one {valid, addr} stage per pipeline cycle; bubbles shift too.
    for (genvar gi = 0; gi < LAT; gi++) begin : g_dly
        logic          vld_reg;
        logic [AW-1:0] addr_reg;
        logic          vld_in;
        logic [AW-1:0] addr_in;

        if (gi == 0) begin : g_head
            assign vld_in  = issue_en;
            assign addr_in = rd_addr_reg;
        end else begin : g_tail
            assign vld_in  = g_dly[gi-1].vld_reg;
            assign addr_in = g_dly[gi-1].addr_reg;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_reg  <= 1'b0;
                addr_reg <= '0;
            end else begin
                vld_reg  <= vld_in;
                addr_reg <= addr_in;
            end
        end
    end

    assign wb_vld  = g_dly[LAT-1].vld_reg;
    assign wb_addr = g_dly[LAT-1].addr_reg;

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.rd_addr  = rd_addr_reg;
    assign bus.sbox_vld = issue_en;
    assign bus.guards   = lfsr_state[GUARD_W-1:0];
    assign bus.wr_addr  = wb_addr;
    assign bus.wr_en    = wb_vld;

endmodule

// File: tb/tb_sbox_seq_ctrl.sv
// Bench for sbox_seq_ctrl: pass-level scoreboard checked every cycle plus
// hand-computed expectations at the interesting cycles of each directed pass.
module tb_sbox_seq_ctrl;
    import sbox_pkg::*;

    localparam int          NB = 16;
    localparam int          LT = 4;
    localparam int          GW = 32;
    localparam logic [31:0] SD = 32'hACE1_2468;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit ok_model = 1'b1;

    sbox_seq_ctrl_if #(.NBYTES(NB), .GUARD_W(GW)) bus();

    sbox_seq_ctrl #(
        .NBYTES  (NB),
        .LAT     (LT),
        .GUARD_W (GW),
        .SEED    (SD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One Galois step of x^32+x^22+x^2+x+1: term x^e feeds back into bit e-1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        logic [31:0] mask;
        mask = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | (32'h1 << 0);
        return (x >> 1) ^ (x[0] ? mask : 32'h0);
    endfunction

    // Scoreboard: a pass is "bytes left to issue" plus a queue of due write-backs.
    typedef struct { int due; int addr; } wb_t;
    wb_t         wq[$];
    bit          m_active   = 1'b0;
    int          m_issued   = 0;
    logic [31:0] m_lfsr     = SD;
    int          m_done_due = -1;

    always @(negedge clk) begin
        bit ev, ew, ed, idle;
        int ea;
        ev = m_active && (m_issued < NB) && ok_model;
        ew = (wq.size() > 0) && (wq[0].due == cyc);
        ea = ew ? wq[0].addr : 0;
        ed = (m_done_due == cyc);
        idle = !m_active && !ed;
        if (chk_en) begin
            chk("busy",     64'(bus.busy),     64'(m_active));
            chk("done",     64'(bus.done),     64'(ed));
            chk("sbox_vld", 64'(bus.sbox_vld), 64'(ev));
            chk("wr_en",    64'(bus.wr_en),    64'(ew));
            if (ev) begin
                chk("rd_addr", 64'(bus.rd_addr), 64'(m_issued));
                chk("guards",  64'(bus.guards),  64'(m_lfsr));
            end
            if (ew) chk("wr_addr", 64'(bus.wr_addr), 64'(ea));
        end
        if (rst) begin
            wq.delete();
            m_active   = 1'b0;
            m_issued   = 0;
            m_lfsr     = SD;
            m_done_due = -1;
        end else begin
            if (ev) begin
                wq.push_back('{due: cyc + LT, addr: m_issued});
                m_issued++;
                m_lfsr = lfsr_step(m_lfsr);
            end
            if (ew) begin
                void'(wq.pop_front());
                if (ea == NB - 1) begin
                    m_active   = 1'b0;
                    m_done_due = cyc + 1;
                end
            end
            if (idle) begin
                if (bus.seed_ld) begin
                    m_lfsr = (bus.seed_i == 32'h0) ? SD : bus.seed_i;
                end else if (bus.start) begin
                    m_active = 1'b1;
                    m_issued = 0;
                end
            end
        end
    end

    task automatic step(input bit st, input bit sl, input logic [31:0] si, input bit r, input bit ok);
        @(posedge clk);
        #1;
        bus.start   = st;
        bus.seed_ld = sl;
        bus.seed_i  = si;
        rst         = r;
        ok_model    = ok;
`ifdef SBOX_SEQ_STALL_EN
        bus.rnd_ok  = ok;
`endif
        #3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        int n;
        bit got;
        bus.start   = 1'b0;
        bus.seed_ld = 1'b0;
        bus.seed_i  = 32'h0;
`ifdef SBOX_SEQ_STALL_EN
        bus.rnd_ok  = 1'b1;
`endif
        step(0, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        chk_en = 1'b1;
        chk("reset_busy",     64'(bus.busy),     64'd0);
        chk("reset_done",     64'(bus.done),     64'd0);
        chk("reset_sbox_vld", 64'(bus.sbox_vld), 64'd0);
        chk("reset_wr_en",    64'(bus.wr_en),    64'd0);
        chk("reset_rd_addr",  64'(bus.rd_addr),  64'd0);
        chk("reset_wr_addr",  64'(bus.wr_addr),  64'd0);
        step(0, 0, 32'h0, 0, 1);

        // Pass A: stray starts at 3 and 21 are ignored, start at 22 runs a second pass.
        done_cnt = 0;
        step(1, 0, 32'h0, 0, 1);
        for (int r = 1; r <= 43; r++) begin
            step((r == 3) || (r == 21) || (r == 22), 0, 32'h0, 0, 1);
            if (r == 1) begin
                chk("a_first_vld",    64'(bus.sbox_vld), 64'd1);
                chk("a_first_addr",   64'(bus.rd_addr),  64'd0);
                chk("a_first_guards", 64'(bus.guards),   64'(SD));
            end
            if (r == 4)  chk("a_wr_not_yet", 64'(bus.wr_en), 64'd0);
            if (r == 5) begin
                chk("a_first_wr",   64'(bus.wr_en),   64'd1);
                chk("a_first_wadr", 64'(bus.wr_addr), 64'd0);
            end
            if (r == 16) chk("a_last_addr", 64'(bus.rd_addr),  64'd15);
            if (r == 17) chk("a_vld_off",   64'(bus.sbox_vld), 64'd0);
            if (r == 20) begin
                chk("a_last_wadr", 64'(bus.wr_addr), 64'd15);
                chk("a_busy_20",   64'(bus.busy),    64'd1);
            end
            if (r == 21) begin
                chk("a_done_21", 64'(bus.done), 64'd1);
                chk("a_busy_21", 64'(bus.busy), 64'd0);
            end
            if (r == 23) chk("a2_first_vld", 64'(bus.sbox_vld), 64'd1);
            if (r == 43) chk("a2_done_43",   64'(bus.done),     64'd1);
            if (bus.done) done_cnt++;
        end
        chk("a_done_count", 64'(done_cnt), 64'd2);
        $display("pass A: two passes, %0d done pulses", done_cnt);

        // Pass B: seed 1, then measure start-to-done length with a bounded wait.
        step(0, 1, 32'h1, 0, 1);
        step(1, 0, 32'h0, 0, 1);
        n = 0;
        got = 1'b0;
        for (int r = 1; r <= 40 && !got; r++) begin
            step(0, 0, 32'h0, 0, 1);
            if (r == 1) chk("b_guards_1", 64'(bus.guards), 64'h1);
            if (r == 2) chk("b_guards_2", 64'(bus.guards), 64'h8020_0003);
            if (bus.done) begin
                got = 1'b1;
                n   = r;
            end
        end
        chk("b_pass_len", 64'(n), 64'd21);
        $display("pass B: seed 1, pass length %0d", n);

        // Pass C: zero seed falls back to SEED; start in the seed cycle is dropped.
        step(1, 1, 32'h0, 0, 1);
        step(0, 0, 32'h0, 0, 1);
        chk("c_start_ignored", 64'(bus.busy), 64'd0);
        step(1, 0, 32'h0, 0, 1);
        for (int r = 1; r <= 22; r++) begin
            step(0, 0, 32'h0, 0, 1);
            if (r == 1) chk("c_guards_seed", 64'(bus.guards), 64'(SD));
        end
        $display("pass C: zero seed replaced by default");

        // Pass D: reset in cycle 8 aborts; the next pass restarts guards at SEED.
        step(1, 0, 32'h0, 0, 1);
        for (int r = 1; r <= 12; r++) begin
            step(0, 0, 32'h0, (r == 8), 1);
            if (r >= 9) begin
                chk("d_abort_wr_en", 64'(bus.wr_en), 64'd0);
                chk("d_abort_busy",  64'(bus.busy),  64'd0);
                chk("d_abort_done",  64'(bus.done),  64'd0);
            end
        end
        step(1, 0, 32'h0, 0, 1);
        for (int r = 1; r <= 22; r++) begin
            step(0, 0, 32'h0, 0, 1);
            if (r == 1)  chk("d_guards_1", 64'(bus.guards), 64'(SD));
            if (r == 2)  chk("d_guards_2", 64'(bus.guards), 64'h5670_9234);
            if (r == 21) chk("d_done_21",  64'(bus.done),   64'd1);
        end
        $display("pass D: mid-pass reset and restart");

`ifdef SBOX_SEQ_STALL_EN
        // Pass E: rnd_ok low on issue cycles 3-5 stretches the pass by three.
        step(1, 0, 32'h0, 0, 1);
        for (int r = 1; r <= 25; r++) begin
            step(0, 0, 32'h0, 0, !((r >= 3) && (r <= 5)));
            if ((r >= 3) && (r <= 5)) begin
                chk("e_hold_addr", 64'(bus.rd_addr),  64'd2);
                chk("e_hold_vld",  64'(bus.sbox_vld), 64'd0);
            end
            if (r == 6)  chk("e_resume_addr", 64'(bus.rd_addr), 64'd2);
            if (r == 23) chk("e_no_done_23",  64'(bus.done),    64'd0);
            if (r == 24) chk("e_done_24",     64'(bus.done),    64'd1);
        end
        $display("pass E: stalled pass");
`endif

        step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox_seq_ctrl.md
Name: sbox_seq_ctrl

Overview:
- Sequencer for one shared, pipelined, 2-share masked S-box datapath built from the GF16 multiply/xor/square-scale units.
- Walks the NBYTES masked state bytes through the datapath, one per cycle, and supplies fresh guard bits for each issued byte from an internal LFSR.
- Tracks in-flight bytes with a LAT-deep delay line and writes each result back to the state register file at its original address.
- Sits between the round controller (start/done) and the state register file and S-box pipeline.

Parameters:
- NBYTES, 16, bytes processed per start
- LAT, 4, S-box pipeline latency in cycles, issue to result (≥1)
- GUARD_W, 32, guard bits supplied per issued byte
- SEED, 32'hACE1_2468, LFSR reset/fallback seed (nonzero)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a pass; sampled in IDLE only
- seed_ld  in  1  load seed_i into LFSR; honoured in IDLE only
- seed_i  in  32  LFSR seed value
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse when last result is written
- rd_addr  out  $clog2(NBYTES)  state byte address presented to regfile/S-box input
- sbox_vld  out  1  issued byte valid this cycle
- guards  out  GUARD_W  fresh randomness for the byte issued this cycle
- wr_addr  out  $clog2(NBYTES)  write-back address
- wr_en  out  1  write S-box result at wr_addr

Behaviour:
- Reset: state=IDLE; busy=0, done=0, sbox_vld=0, wr_en=0, rd_addr=0, wr_addr=0; delay line cleared; LFSR=SEED.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 → ISSUE with issue counter=0.
  - seed_ld has priority over start in the same cycle: seed loads, start is ignored that cycle.
  - A seed_i of 0 loads SEED instead, to avoid LFSR lockup.
- ISSUE:
  - Every cycle: sbox_vld=1, rd_addr=counter, guards=LFSR[GUARD_W-1:0]; the LFSR steps once; counter increments.
  - When counter==NBYTES-1 is issued → DRAIN.
- Delay line: LAT stages of {valid, addr}. Entry at stage 0 = {sbox_vld, rd_addr}. Output stage drives wr_en and wr_addr.
- DRAIN: no issue; the LFSR holds. When the final write-back occurs (wr_en=1 and wr_addr==NBYTES-1) → DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Timing:
  - First wr_en occurs exactly LAT cycles after the first sbox_vld.
  - Pass length start→done = NBYTES+LAT+1 cycles (NBYTES=16, LAT=4 → 21).
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
  - Advances only on issue cycles, so every byte sees distinct guards and randomness is never reused across bytes.
- start while busy or in DONE: ignored; no queuing.
- rst mid-pass:
  - Aborts the pass next edge; no further wr_en; done is not asserted.
  - LFSR returns to SEED.
- sbox_vld and wr_en may be high in the same cycle; the register file must support simultaneous read/write of different addresses (guaranteed when LAT ≥ 1).

Optional Feature:
- Macro SBOX_SEQ_STALL_EN.
- When defined:
  - Adds input rnd_ok (1 bit).
  - In ISSUE, a byte is issued only if rnd_ok=1. Otherwise sbox_vld=0, the counter and LFSR hold, and a bubble enters the delay line.
  - The delay line keeps shifting, so in-flight bytes complete.
  - Pass length = NBYTES+LAT+1+stall cycles.
- When undefined: the port is absent and behaviour is as if rnd_ok=1.

Decomposition:
- Shared package sbox_pkg:
  - FSM state enum sbox_seq_state_t.
  - LFSR polynomial constant SBOX_LFSR_POLY.
  - Default SEED.
  - Address width function.
- Sub-module guard_lfsr: seeded Galois LFSR with step, load and zero-seed substitution; reused by other masked units.
- The delay line stays inline.

Test Plan:
- Reset then start=1 for one cycle, NBYTES=16, LAT=4:
  - sbox_vld high in cycles 1–16 with rd_addr 0..15.
  - wr_en high in cycles 5–20 with wr_addr 0..15.
  - done pulse in cycle 21; busy high in cycles 1–20.
- seed_ld with seed_i=32'h1 then start: guards in the first issue cycle = 32'h1; the second equals one Galois step of 32'h1 per SBOX_LFSR_POLY.
- seed_ld with seed_i=0: the first issued guards value equals SEED (32'hACE1_2468).
- start pulsed again in cycles 3 and 21: both are ignored, with exactly one done per pass; a start in cycle 22 (IDLE) begins a new pass.
- rst asserted in cycle 8:
  - From cycle 9: wr_en=0, busy=0, no done.
  - After release, a new start reproduces the guard sequence beginning at SEED.
- With SBOX_SEQ_STALL_EN, rnd_ok=0 on issue cycles 3–5:
  - rd_addr 2 is held while rnd_ok=0.
  - The write-back sequence is 0..15 with a 3-cycle gap.
  - done arrives in cycle 24.
